// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared encodings for the ALU operation sequencer: op select
//                codes, sequencer state enum and response flag bit indices.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

   // Op select encodings driven onto the ALU Sel bus
   localparam logic [1:0] SEL_ADD = 2'b00;
   localparam logic [1:0] SEL_SUB = 2'b01;
   localparam logic [1:0] SEL_AND = 2'b10;
   localparam logic [1:0] SEL_CMP = 2'b11;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Bit positions inside rsp_flags = {eq, gt, lt}
   localparam int FLAG_EQ = 2;
   localparam int FLAG_GT = 1;
   localparam int FLAG_LT = 0;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Request/response front end for a combinational 4-bit ALU.
//                Accepts one op per request handshake, holds the operand bus
//                for SETTLE_CYCLES, captures the selected result and compare
//                flags, and presents them on a valid/ready response port.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 1,   // legal range 1..15
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   // request port
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [1:0]       req_sel,
   // ALU operand bus
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_sel,
   // ALU result bus
   input  logic [WIDTH:0]   alu_y_add,
   input  logic [WIDTH:0]   alu_y_sub,
   input  logic [WIDTH-1:0] alu_y_and,
   input  logic             alu_eq,
   input  logic             alu_gt,
   input  logic             alu_lt,
   // response port
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH:0]   rsp_data,
   output logic [2:0]       rsp_flags,
   output logic [1:0]       rsp_sel,
   // status
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   // Counter is loaded with SETTLE_CYCLES-1 so that a value of 0 means
   // "capture on the next edge"; 4 bits cover the legal range 1..15.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [1:0]       alu_sel_q, alu_sel_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH:0]   rsp_data_q, rsp_data_d;
   logic [2:0]       rsp_flags_q, rsp_flags_d;
   logic [1:0]       rsp_sel_q, rsp_sel_d;
   logic             req_ready_q, req_ready_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   logic [WIDTH:0]   capture_data;
   logic [2:0]       capture_flags;

   // State and output registers; reset leaves only req_ready asserted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
         rsp_sel_q   <= '0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sel_q   <= alu_sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
         rsp_sel_q   <= rsp_sel_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         op_count_q  <= op_count_d;
      end
   end

   // Next-state logic: one op in flight, requests outside IDLE are ignored
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid)     state_d = SETTLE;
         SETTLE:  if (cnt_q == 4'd0) state_d = RESP;
         RESP:    if (rsp_ready)     state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Result select: the sub result passes through as 5-bit two's complement
   always_comb begin
      capture_data = '0;
      case (alu_sel_q)
         SEL_ADD: capture_data = alu_y_add;
         SEL_SUB: capture_data = alu_y_sub;
         SEL_AND: capture_data = {1'b0, alu_y_and};
         SEL_CMP: capture_data = '0;
         default: capture_data = '0;
      endcase
      capture_flags          = '0;
      capture_flags[FLAG_EQ] = alu_eq;
      capture_flags[FLAG_GT] = alu_gt;
      capture_flags[FLAG_LT] = alu_lt;
   end

   // Registered-output next values; handshake status is derived from state_d
   // so req_ready/busy line up with the state they describe
   always_comb begin
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_sel_d   = alu_sel_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;
      rsp_sel_d   = rsp_sel_q;
      op_count_d  = op_count_q;
      req_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               alu_a_d   = req_a;
               alu_b_d   = req_b;
               alu_sel_d = req_sel;
               cnt_d     = SETTLE_LOAD;
            end
         end
         SETTLE: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rsp_data_d  = capture_data;
               rsp_flags_d = capture_flags;
               rsp_sel_d   = alu_sel_q;
               rsp_valid_d = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               op_count_d  = op_count_q + CNT_W'(1);
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_flags = rsp_flags_q;
   assign rsp_sel   = rsp_sel_q;
   assign req_ready = req_ready_q;
   assign busy      = busy_q;
   assign op_count  = op_count_q;

endmodule : alu_op_sequencer
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Self-checking bench for alu_op_sequencer. Instance u_dut0
//                uses default parameters and a response scoreboard; u_dut1
//                uses SETTLE_CYCLES=4, CNT_W=2 for latency, wrap and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- instance 0 (defaults) ----------------
   logic       rst, req_valid, req_ready, rsp_valid, rsp_ready, busy;
   logic [3:0] req_a, req_b, alu_a, alu_b, y_and;
   logic [1:0] req_sel, alu_sel, rsp_sel;
   logic [4:0] y_add, y_sub, rsp_data;
   logic [2:0] rsp_flags;
   logic       eq, gt, lt;
   logic [7:0] op_count;

   // ---------------- instance 1 (SETTLE=4, CNT_W=2) --------
   logic       rst1, req_valid1, req_ready1, rsp_valid1, rsp_ready1, busy1;
   logic [3:0] req_a1, req_b1, alu_a1, alu_b1, y_and1;
   logic [1:0] req_sel1, alu_sel1, rsp_sel1;
   logic [4:0] y_add1, y_sub1, rsp_data1;
   logic [2:0] rsp_flags1;
   logic       eq1, gt1, lt1;
   logic [1:0] op_count1;

   // Behavioural stand-in for the external four_bit_ALU
   assign y_add  = {1'b0, alu_a} + {1'b0, alu_b};
   assign y_sub  = {1'b0, alu_a} - {1'b0, alu_b};
   assign y_and  = alu_a & alu_b;
   assign eq     = (alu_a == alu_b);
   assign gt     = (alu_a >  alu_b);
   assign lt     = (alu_a <  alu_b);
   assign y_add1 = {1'b0, alu_a1} + {1'b0, alu_b1};
   assign y_sub1 = {1'b0, alu_a1} - {1'b0, alu_b1};
   assign y_and1 = alu_a1 & alu_b1;
   assign eq1    = (alu_a1 == alu_b1);
   assign gt1    = (alu_a1 >  alu_b1);
   assign lt1    = (alu_a1 <  alu_b1);

   alu_op_sequencer u_dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_y_add(y_add), .alu_y_sub(y_sub), .alu_y_and(y_and),
      .alu_eq(eq), .alu_gt(gt), .alu_lt(lt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_sel(rsp_sel),
      .busy(busy), .op_count(op_count)
   );

   alu_op_sequencer #(.WIDTH(4), .SETTLE_CYCLES(4), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst(rst1),
      .req_valid(req_valid1), .req_ready(req_ready1),
      .req_a(req_a1), .req_b(req_b1), .req_sel(req_sel1),
      .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1),
      .alu_y_add(y_add1), .alu_y_sub(y_sub1), .alu_y_and(y_and1),
      .alu_eq(eq1), .alu_gt(gt1), .alu_lt(lt1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .rsp_data(rsp_data1), .rsp_flags(rsp_flags1), .rsp_sel(rsp_sel1),
      .busy(busy1), .op_count(op_count1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [4:0] data;
      logic [2:0] flags;
      logic [1:0] sel;
   } rsp_t;

   rsp_t sbq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every response handshake on instance 0 is matched against the queue
   always @(negedge clk) begin
      if (!rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_unexpected: got data=0x%0h flags=0x%0h sel=%0d expected no response",
                     rsp_data, rsp_flags, rsp_sel);
         end else begin
            rsp_t e;
            e = sbq.pop_front();
            chk("rsp_data_flags_sel", 32'({rsp_data, rsp_flags, rsp_sel}), 32'(e));
         end
      end
   end

   // Present a request to instance 0 at a falling edge and push its expected response
   task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel,
                        input logic [4:0] ed, input logic [2:0] ef);
      int t = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_a = a; req_b = b; req_sel = sel; req_valid = 1'b1;
      sbq.push_back('{data: ed, flags: ef, sel: sel});
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((busy !== 1'b0 || rsp_valid !== 1'b0) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("drain_timeout", 32'(busy), 32'd0);
   endtask

   task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
      int t = 0;
      @(negedge clk);
      while (req_ready1 !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("req_ready1_timeout", 32'(req_ready1), 32'd1);
      req_a1 = a; req_b1 = b; req_sel1 = sel; req_valid1 = 1'b1;
      @(posedge clk);
      #1 req_valid1 = 1'b0;
   endtask

   task automatic drain1();
      int t = 0;
      while ((busy1 !== 1'b0 || rsp_valid1 !== 1'b0) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("drain1_timeout", 32'(busy1), 32'd0);
   endtask

   // Hard stop if anything wedges
   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected $finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; rst1 = 1'b0;
      req_valid = 1'b0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b1;
      req_valid1 = 1'b0; req_a1 = '0; req_b1 = '0; req_sel1 = '0; rsp_ready1 = 1'b1;
      #1 rst = 1'b1; rst1 = 1'b1;
      @(negedge clk);
      @(negedge clk);

      // ---- reset state ----
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_op_count",  32'(op_count),  32'd0);
      chk("rst_alu_bus",   32'({alu_a, alu_b, alu_sel}), 32'd0);
      chk("rst_rsp_bus",   32'({rsp_data, rsp_flags, rsp_sel}), 32'd0);
      rst = 1'b0; rst1 = 1'b0;

      // ---- add 15+15 with latency check ----
      issue(4'b1111, 4'b1111, 2'b00, 5'b11110, 3'b100);
      chk("add_valid_at_T",     32'(rsp_valid), 32'd0);
      chk("add_req_ready_at_T", 32'(req_ready), 32'd0);
      chk("add_busy_at_T",      32'(busy),      32'd1);
      chk("add_alu_bus",        32'({alu_a, alu_b, alu_sel}), 32'({4'hF, 4'hF, 2'b00}));
      @(posedge clk);
      #1 chk("add_valid_at_T1", 32'(rsp_valid), 32'd1);
      drain();
      chk("add_op_count", 32'(op_count), 32'd1);

      // ---- sub / and / compare on 15,15; then 3-5 ----
      issue(4'b1111, 4'b1111, 2'b01, 5'b00000, 3'b100); drain();
      issue(4'b1111, 4'b1111, 2'b10, 5'b01111, 3'b100); drain();
      issue(4'b1111, 4'b1111, 2'b11, 5'b00000, 3'b100); drain();
      issue(4'd3,    4'd5,    2'b01, 5'b11110, 3'b001); drain();
      chk("seq_op_count", 32'(op_count), 32'd5);

      // ---- backpressure: 9+4 held for 10 cycles ----
      rsp_ready = 1'b0;
      issue(4'd9, 4'd4, 2'b00, 5'b01101, 3'b010);
      begin
         int t = 0;
         while (rsp_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
         end
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold_rsp", 32'({rsp_valid, rsp_data, rsp_flags, rsp_sel}),
             32'({1'b1, 5'b01101, 3'b010, 2'b00}));
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         if (i == 3) begin
            req_a = 4'd2; req_b = 4'd2; req_sel = 2'b01; req_valid = 1'b1;
         end
         if (i == 6) req_valid = 1'b0;
      end
      chk("bp_alu_bus_held", 32'({alu_a, alu_b, alu_sel}), 32'({4'd9, 4'd4, 2'b00}));
      chk("bp_count_stalled", 32'(op_count), 32'd5);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      drain();
      chk("bp_op_count", 32'(op_count), 32'd6);
      repeat (3) @(negedge clk);
      chk("bp_no_extra_valid", 32'(rsp_valid), 32'd0);
      chk("bp_idle_ready",     32'(req_ready), 32'd1);
      chk("sb_empty",          32'(sbq.size()), 32'd0);

      // ---- instance 1: SETTLE_CYCLES=4 latency (6-3) ----
      issue1(4'd6, 4'd3, 2'b01);
      chk("s4_valid_T0", 32'(rsp_valid1), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         chk("s4_valid_early", 32'(rsp_valid1), 32'd0);
         chk("s4_bus_stable", 32'({alu_a1, alu_b1, alu_sel1}), 32'({4'd6, 4'd3, 2'b01}));
      end
      @(posedge clk);
      #1;
      chk("s4_valid_T4", 32'(rsp_valid1), 32'd1);
      chk("s4_rsp", 32'({rsp_data1, rsp_flags1, rsp_sel1}), 32'({5'b00011, 3'b010, 2'b01}));
      drain1();
      chk("s4_op_count", 32'(op_count1), 32'd1);

      // ---- instance 1: op_count wrap with CNT_W=2 ----
      issue1(4'd1, 4'd2, 2'b00); drain1();
      issue1(4'd7, 4'd7, 2'b10); drain1();
      issue1(4'd0, 4'd1, 2'b11); drain1();
      chk("wrap_after4", 32'(op_count1), 32'd0);
      issue1(4'd5, 4'd5, 2'b00); drain1();
      chk("wrap_op5", 32'(op_count1), 32'd1);
      chk("wrap_op5_data", 32'(rsp_data1), 32'd10);

      // ---- instance 1: asynchronous reset mid-SETTLE ----
      issue1(4'd8, 4'd1, 2'b00);
      @(negedge clk);
      chk("mid_busy_before_rst", 32'(busy1), 32'd1);
      #2 rst1 = 1'b1;
      #1;
      chk("mid_rst_req_ready", 32'(req_ready1), 32'd1);
      chk("mid_rst_outputs", 32'({busy1, rsp_valid1, op_count1, alu_a1, alu_b1, alu_sel1,
                                  rsp_data1, rsp_flags1, rsp_sel1}), 32'd0);
      @(negedge clk);
      rst1 = 1'b0;
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid1 !== 1'b0) seen = 1'b1;
         end
         chk("mid_no_rsp_after_rst", 32'(seen), 32'd0);
      end
      chk("mid_count_after_rst", 32'(op_count1), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_alu_op_sequencer
`default_nettype wire
